// File: rtl/bsg_reduce_pkg.sv
// Shared types for the serial reduction engine: op encoding and FSM states.
package bsg_reduce_pkg;

    typedef enum logic [1:0] {
        e_reduce_or  = 2'b00,
        e_reduce_and = 2'b01,
        e_reduce_xor = 2'b10
    } bsg_reduce_op_e;

    typedef enum logic [1:0] {
        eIdle,
        eBusy,
        eDone
    } bsg_reduce_state_e;

    // Accumulator seed: AND starts at 1, OR/XOR (and the reserved code) at 0.
    function automatic logic reduce_identity(input logic [1:0] op);
        return op == e_reduce_and;
    endfunction

endpackage

// File: rtl/bsg_reduce.sv
// Single-cycle reduction of a vector to one bit; exactly one of xor_p/and_p/or_p is set.
module bsg_reduce #(
    parameter int width_p = 1,
    parameter bit xor_p   = 1'b0,
    parameter bit and_p   = 1'b0,
    parameter bit or_p    = 1'b0
) (
    input  logic [width_p-1:0] i,
    output logic               o
);

    generate
        if (xor_p) begin : g_xor
            assign o = ^i;
        end else if (and_p) begin : g_and
            assign o = &i;
        end else if (or_p) begin : g_or
            assign o = |i;
        end else begin : g_none
            assign o = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/bsg_reduce_serial.sv
// Multi-cycle OR/AND/XOR reduction of a wide word, chunk_p bits per cycle,
// with a valid/ready input side and a valid/yumi result side.
module bsg_reduce_serial
    import bsg_reduce_pkg::*;
#(
    parameter int width_p = 64,
    parameter int chunk_p = 16
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    input  logic [1:0]         op_i,
    output logic               ready_o,
    output logic               v_o,
    output logic               data_o,
    input  logic               yumi_i
);

    localparam int els_lp   = width_p / chunk_p;
    localparam int cnt_w_lp = (els_lp > 1) ? $clog2(els_lp) : 1;
    localparam int off_w_lp = (width_p > 1) ? $clog2(width_p) : 1;
    localparam logic [cnt_w_lp-1:0] cnt_last_lp = cnt_w_lp'(els_lp - 1);

    bsg_reduce_state_e   state_r;
    logic [width_p-1:0]  data_r;
    logic [1:0]          op_r;
    logic [cnt_w_lp-1:0] cnt_r;
    logic                acc_r;

    logic [off_w_lp-1:0] chunk_off;
    logic [chunk_p-1:0]  chunk;
    logic                or_lo, and_lo, xor_lo;
    logic                acc_n;

    assign chunk_off = off_w_lp'(cnt_r * chunk_p);
    assign chunk     = data_r[chunk_off +: chunk_p];

    bsg_reduce #(.width_p(chunk_p), .or_p(1'b1))  red_or  (.i(chunk), .o(or_lo));
    bsg_reduce #(.width_p(chunk_p), .and_p(1'b1)) red_and (.i(chunk), .o(and_lo));
    bsg_reduce #(.width_p(chunk_p), .xor_p(1'b1)) red_xor (.i(chunk), .o(xor_lo));

    // Reserved op code 11 falls into the OR arm.
    always_comb begin
        acc_n = acc_r | or_lo;
        case (op_r)
            e_reduce_and: acc_n = acc_r & and_lo;
            e_reduce_xor: acc_n = acc_r ^ xor_lo;
            default:      acc_n = acc_r | or_lo;
        endcase
    end

    assign ready_o = (state_r == eIdle) && !reset_i;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r <= eIdle;
            data_r  <= '0;
            op_r    <= '0;
            cnt_r   <= '0;
            acc_r   <= 1'b0;
            v_o     <= 1'b0;
            data_o  <= 1'b0;
        end else begin
            case (state_r)
                eIdle: begin
                    if (v_i) begin
                        data_r  <= data_i;
                        op_r    <= op_i;
                        cnt_r   <= '0;
                        acc_r   <= reduce_identity(op_i);
                        state_r <= eBusy;
                    end
                end
                eBusy: begin
                    acc_r <= acc_n;
                    if (cnt_r == cnt_last_lp) begin
                        state_r <= eDone;
                        v_o     <= 1'b1;
                        data_o  <= acc_n;
                    end else begin
                        cnt_r <= cnt_r + cnt_w_lp'(1);
                    end
                end
                eDone: begin
                    if (yumi_i) begin
                        state_r <= eIdle;
                        v_o     <= 1'b0;
                    end
                end
                default: state_r <= eIdle;
            endcase
        end
    end

`ifndef SYNTHESIS
    generate
        if (width_p % chunk_p != 0) begin : g_bad_chunk
            $error("bsg_reduce_serial: width_p must be a multiple of chunk_p");
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            assert (!(yumi_i && !v_o))
                else $error("bsg_reduce_serial: yumi_i without v_o");
            if (v_i && ready_o)
                assert (!$isunknown({data_i, op_i}))
                    else $error("bsg_reduce_serial: X on data_i/op_i at handshake");
        end
    end
`endif

endmodule

// File: doc/bsg_reduce_serial.md
Name: bsg_reduce_serial

Overview:
- Multi-cycle reduction engine. Accepts one width_p-bit word and a reduction op (OR/AND/XOR) over a valid/ready handshake.
- Sequences the word through a chunk_p-bit combinational reducer, one chunk per cycle, and accumulates the partial result.
- Presents the 1-bit result on a valid/yumi handshake.
- Sits beside wide status/mask vectors where a full-width single-cycle reduce tree breaks timing or area.

Parameters:
- width_p, 64, input word width; must be a multiple of chunk_p.
- chunk_p, 16, bits reduced per cycle; 1 <= chunk_p <= width_p.
- els_lp, width_p/chunk_p, derived local: number of chunks.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous active-high reset
- v_i  in  1  input word valid
- data_i  in  width_p  word to reduce
- op_i  in  2  reduction op: 00 OR, 01 AND, 10 XOR, 11 reserved (treated as OR)
- ready_o  out  1  engine can accept a word
- v_o  out  1  result valid
- data_o  out  1  reduction result
- yumi_i  in  1  consumer takes result; legal only when v_o=1

Behaviour:
- Reset values (registered, synchronous): state=eIdle, v_o=0, data_o=0, chunk counter=0, accumulator=0. ready_o=0 while reset_i=1, 1 in the first cycle after reset.
- Decided interface: one clock (clk_i); reset (reset_i) is synchronous and active-high.
- States: eIdle, eBusy, eDone.
- eIdle:
  - ready_o=1.
  - On v_i&ready_o, latch data_i and op_i, clear the counter, and load the accumulator identity (OR 0, AND 1, XOR 0). Next state is eBusy.
- eBusy:
  - ready_o=0. v_i is ignored and data_i is not sampled.
  - Each cycle: acc <= acc op reduce_op(chunk[cnt]). Chunk k is bits [k*chunk_p +: chunk_p]; chunks are processed in ascending order, chunk 0 first.
  - On cnt==els_lp-1, perform the final accumulation and go to eDone. Otherwise cnt++.
- eDone:
  - v_o=1 and data_o=acc, held stable until yumi_i.
  - On yumi_i, go to eIdle; v_o drops the next cycle.
  - ready_o=0 in eDone. No fall-through: a new word is accepted no earlier than the cycle after yumi_i.
- Latency:
  - Handshake accepted at edge T0; v_o is first high in cycle T0+els_lp+1.
  - Minimum initiation interval is els_lp+2 cycles.
  - chunk_p==width_p gives exactly one eBusy cycle.
- Counter width: `$clog2(els_lp)`, minimum 1 bit. No wrap beyond els_lp-1.
- Reserved op 11 computes OR. It is not an error.
- reset_i asserted in any state:
  - The next state is eIdle with v_o=0.
  - An in-flight result is discarded silently.
  - reset_i has priority over v_i and yumi_i in the same cycle.
- Assertions (simulation only):
  - yumi_i while v_o=0.
  - width_p % chunk_p != 0.
  - data_i/op_i X when v_i&ready_o.

Decomposition:
- Shared package bsg_reduce_pkg: enum bsg_reduce_op_e {e_reduce_or=2'b00, e_reduce_and=2'b01, e_reduce_xor=2'b10}, plus the state enum.
- Chunk reducer: three instances of the existing bsg_reduce (or_p / and_p / xor_p, width_p=chunk_p) on the selected chunk.
  - Result is muxed by the latched op.
  - Chunk selection is an indexed part-select on the latched word; no separate mux module.
- Top-level FSM, counter and accumulator live in bsg_reduce_serial itself.

Test Plan:
- Reset then idle: hold reset_i 3 cycles, release -> ready_o=1, v_o=0, data_o=0. No v_o for 20 idle cycles.
- OR single bit: op=00, data_i=64'h8000_0000_0000_0000 (chunk 3 only), accepted at T0 -> v_o rises at T0+5, data_o=1. data_i=0 -> data_o=0.
- AND boundary: op=01, data_i=all ones -> data_o=1. data_i=all ones except bit 0 -> data_o=0. Both at T0+5.
- XOR parity plus reserved op:
  - op=10, data_i=64'h0000_0001_0000_0003 -> data_o=1 (three ones).
  - op=11 with data_i=64'h10 -> data_o=1.
- Backpressure/handshake:
  - Hold yumi_i=0 for 10 cycles in eDone -> v_o/data_o stable, ready_o=0.
  - Toggle v_i during eBusy with a different word -> result unaffected.
  - yumi_i at cycle N -> ready_o=1 at N+1, next word accepted at N+1.
- Reset mid-operation and parameter sweep:
  - Assert reset_i at T0+2 -> v_o never rises; engine returns to eIdle at T0+3.
  - Rerun the OR/AND/XOR cases with chunk_p=64 (latency 2) and chunk_p=1 (latency 65).
